lc4_iq_controller: RTL and testbench

- Owns the state of the 4-entry out-of-order issue queue: entry storage, valid/issue/commit status bits and the head (oldest) pointer.
- The issue-select logic and the memory-ordering queue consume all of this state as a flat view.
- Allocates entries at dispatch, marks entries issued on the select grant, and marks them complete on execution writeback.
- Retires the head entry in program order and frees it.

---
 rtl/lc4_iq_pkg.sv | 24 ++
 rtl/lc4_iq_controller_if.sv | 53 +++++
 rtl/lc4_iq_entry.sv | 55 +++++
 rtl/lc4_iq_controller.sv | 99 +++++++++
 tb/tb_lc4_iq_controller.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc4_iq_pkg.sv
// Shared types and constants for the 4-entry issue queue: widths, entry payload
// layout and the modulo-4 pointer step.
package lc4_iq_pkg;

  localparam int IQ_DEPTH = 4;
  localparam int IQ_IDX_W = 2;
  localparam int PR_W     = 4;
  localparam int INSN_W   = 16;

  typedef logic [IQ_IDX_W-1:0] iq_idx_t;

  // Payload of one slot; status bits live beside it in lc4_iq_entry.
  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [PR_W-1:0]   pr1;
    logic [PR_W-1:0]   pr2;
    logic [PR_W-1:0]   prd;
  } iq_entry_t;

  function automatic iq_idx_t ptr_inc(input iq_idx_t p);
    return p + iq_idx_t'(1);
  endfunction

endpackage

// File: rtl/lc4_iq_controller_if.sv
// Dispatch / issue / complete / retire bus of the issue queue plus the flat
// per-entry state view consumed by select logic and the memory-ordering queue.
interface lc4_iq_controller_if;
  import lc4_iq_pkg::*;

  logic              flush;
  logic              dp_valid;
  logic [INSN_W-1:0] dp_insn;
  logic [PR_W-1:0]   dp_pr1;
  logic [PR_W-1:0]   dp_pr2;
  logic [PR_W-1:0]   dp_prd;
  logic              dp_ready;
  logic              is_valid;
  iq_idx_t           is_index;
  logic              cm_valid;
  iq_idx_t           cm_index;

  logic [INSN_W-1:0] iq0_insn, iq1_insn, iq2_insn, iq3_insn;
  logic [PR_W-1:0]   iq0_pr1, iq1_pr1, iq2_pr1, iq3_pr1;
  logic [PR_W-1:0]   iq0_pr2, iq1_pr2, iq2_pr2, iq3_pr2;
  logic [PR_W-1:0]   iq0_prd, iq1_prd, iq2_prd, iq3_prd;
  logic [3:0]        iq_valid, iq_issue, iq_commit;
  iq_idx_t           iq_rd;
  logic              rt_valid;
  iq_idx_t           rt_index;
  logic [INSN_W-1:0] rt_insn;
  logic [PR_W-1:0]   rt_prd;

  modport master (
    output flush, dp_valid, dp_insn, dp_pr1, dp_pr2, dp_prd,
           is_valid, is_index, cm_valid, cm_index,
    input  dp_ready,
           iq0_insn, iq1_insn, iq2_insn, iq3_insn,
           iq0_pr1, iq1_pr1, iq2_pr1, iq3_pr1,
           iq0_pr2, iq1_pr2, iq2_pr2, iq3_pr2,
           iq0_prd, iq1_prd, iq2_prd, iq3_prd,
           iq_valid, iq_issue, iq_commit, iq_rd,
           rt_valid, rt_index, rt_insn, rt_prd
  );

  modport slave (
    input  flush, dp_valid, dp_insn, dp_pr1, dp_pr2, dp_prd,
           is_valid, is_index, cm_valid, cm_index,
    output dp_ready,
           iq0_insn, iq1_insn, iq2_insn, iq3_insn,
           iq0_pr1, iq1_pr1, iq2_pr1, iq3_pr1,
           iq0_pr2, iq1_pr2, iq2_pr2, iq3_pr2,
           iq0_prd, iq1_prd, iq2_prd, iq3_prd,
           iq_valid, iq_issue, iq_commit, iq_rd,
           rt_valid, rt_index, rt_insn, rt_prd
  );

endinterface

// File: rtl/lc4_iq_entry.sv
// One issue-queue slot: payload register plus valid/issue/commit status, driven
// by write, issue, commit and clear strobes that the top module qualifies.
module lc4_iq_entry
  import lc4_iq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      wr_en,
  input  iq_entry_t wr_data,
  input  logic      set_issue,
  input  logic      set_commit,
  input  logic      clear,
  output iq_entry_t data,
  output logic      valid,
  output logic      issue,
  output logic      commit
);

  iq_entry_t data_reg;
  logic      valid_reg, issue_reg, commit_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      issue_reg  <= 1'b0;
      commit_reg <= 1'b0;
    end else begin
      // Flush kills status only; the payload of a squashed slot is kept.
      if (wr_en && !flush)
        data_reg <= wr_data;
      if (flush || clear) begin
        valid_reg  <= 1'b0;
        issue_reg  <= 1'b0;
        commit_reg <= 1'b0;
      end else if (wr_en) begin
        valid_reg  <= 1'b1;
        issue_reg  <= 1'b0;
        commit_reg <= 1'b0;
      end else begin
        if (set_issue)
          issue_reg <= 1'b1;
        if (set_commit)
          commit_reg <= 1'b1;
      end
    end
  end

  assign data   = data_reg;
  assign valid  = valid_reg;
  assign issue  = issue_reg;
  assign commit = commit_reg;

endmodule

// File: rtl/lc4_iq_controller.sv
// Issue-queue state owner: allocates at the tail, tracks issue/complete per slot,
// and retires the head in program order.
module lc4_iq_controller
  import lc4_iq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  lc4_iq_controller_if.slave  iq
);

  iq_idx_t              head_reg, head_next;
  logic [2:0]           count_reg, count_next;
  iq_idx_t              tail;
  logic                 dp_ready, dp_fire, rt_fire;
  iq_entry_t            dp_data;
  iq_entry_t            ent_data [IQ_DEPTH];
  logic [IQ_DEPTH-1:0]  valid_vec, issue_vec, commit_vec;

  // Ready looks only at registered count: a same-cycle retire frees nothing.
  assign dp_ready = (count_reg != 3'd4);
  assign dp_fire  = iq.dp_valid && dp_ready && !iq.flush;
  assign tail     = head_reg + count_reg[1:0];
  assign rt_fire  = valid_vec[head_reg] && commit_vec[head_reg];

  assign dp_data.insn = iq.dp_insn;
  assign dp_data.pr1  = iq.dp_pr1;
  assign dp_data.pr2  = iq.dp_pr2;
  assign dp_data.prd  = iq.dp_prd;

  // Issue/complete are qualified against registered status; clear wins inside the slot.
  for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_ent
    lc4_iq_entry u_entry (
      .clk        (clk),
      .rst        (rst),
      .flush      (iq.flush),
      .wr_en      (dp_fire && (tail == iq_idx_t'(gi))),
      .wr_data    (dp_data),
      .set_issue  (iq.is_valid && (iq.is_index == iq_idx_t'(gi)) &&
                   valid_vec[gi] && !issue_vec[gi]),
      .set_commit (iq.cm_valid && (iq.cm_index == iq_idx_t'(gi)) &&
                   valid_vec[gi] && issue_vec[gi]),
      .clear      (rt_fire && (head_reg == iq_idx_t'(gi))),
      .data       (ent_data[gi]),
      .valid      (valid_vec[gi]),
      .issue      (issue_vec[gi]),
      .commit     (commit_vec[gi])
    );
  end

  always_comb begin
    head_next  = head_reg;
    count_next = count_reg;
    if (rt_fire)
      head_next = ptr_inc(head_reg);
    case ({dp_fire, rt_fire})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || iq.flush) begin
      head_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      count_reg <= count_next;
    end
  end

  assign iq.dp_ready  = dp_ready;
  assign iq.iq_valid  = valid_vec;
  assign iq.iq_issue  = issue_vec;
  assign iq.iq_commit = commit_vec;
  assign iq.iq_rd     = head_reg;
  assign iq.rt_valid  = rt_fire;
  assign iq.rt_index  = head_reg;
  assign iq.rt_insn   = ent_data[head_reg].insn;
  assign iq.rt_prd    = ent_data[head_reg].prd;

  assign iq.iq0_insn = ent_data[0].insn;
  assign iq.iq1_insn = ent_data[1].insn;
  assign iq.iq2_insn = ent_data[2].insn;
  assign iq.iq3_insn = ent_data[3].insn;
  assign iq.iq0_pr1  = ent_data[0].pr1;
  assign iq.iq1_pr1  = ent_data[1].pr1;
  assign iq.iq2_pr1  = ent_data[2].pr1;
  assign iq.iq3_pr1  = ent_data[3].pr1;
  assign iq.iq0_pr2  = ent_data[0].pr2;
  assign iq.iq1_pr2  = ent_data[1].pr2;
  assign iq.iq2_pr2  = ent_data[2].pr2;
  assign iq.iq3_pr2  = ent_data[3].pr2;
  assign iq.iq0_prd  = ent_data[0].prd;
  assign iq.iq1_prd  = ent_data[1].prd;
  assign iq.iq2_prd  = ent_data[2].prd;
  assign iq.iq3_prd  = ent_data[3].prd;

endmodule

// File: tb/tb_lc4_iq_controller.sv
// Directed bench for lc4_iq_controller: state checks from the stimulus thread,
// retire traffic checked by a monitor against a queue of expected retirements.
module tb_lc4_iq_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lc4_iq_controller_if bus ();

  lc4_iq_controller dut (
    .clk (clk),
    .rst (rst),
    .iq  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] insn;
    logic [3:0]  prd;
  } rt_exp_t;

  rt_exp_t    exp_q [$];
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         n_retired = 0;
  logic [1:0] m_tail    = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush    = 1'b0;
    bus.dp_valid = 1'b0;
    bus.is_valid = 1'b0;
    bus.cm_valid = 1'b0;
  endtask

  task automatic set_dp(input logic [15:0] insn, input logic [3:0] prd);
    bus.dp_valid = 1'b1;
    bus.dp_insn  = insn;
    bus.dp_prd   = prd;
    bus.dp_pr1   = prd + 4'd1;
    bus.dp_pr2   = prd + 4'd2;
  endtask

  task automatic push_exp(input logic [15:0] insn, input logic [3:0] prd);
    rt_exp_t e;
    e.idx  = m_tail;
    e.insn = insn;
    e.prd  = prd;
    exp_q.push_back(e);
    m_tail = m_tail + 2'd1;
  endtask

  // Dispatch that the caller knows will be accepted.
  task automatic dispatch(input logic [15:0] insn, input logic [3:0] prd);
    set_dp(insn, prd);
    tick();
    bus.dp_valid = 1'b0;
    push_exp(insn, prd);
  endtask

  task automatic issue(input logic [1:0] idx);
    bus.is_valid = 1'b1;
    bus.is_index = idx;
    tick();
    bus.is_valid = 1'b0;
  endtask

  task automatic complete(input logic [1:0] idx);
    bus.cm_valid = 1'b1;
    bus.cm_index = idx;
    tick();
    bus.cm_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    rt_exp_t e;
    if (rst === 1'b0 && bus.rt_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL retire_unexpected: got idx %0d, expected no retire", bus.rt_index);
      end else begin
        e = exp_q.pop_front();
        n_retired++;
        $display("retire idx=%0d insn=0x%04h prd=%0d", bus.rt_index, bus.rt_insn, bus.rt_prd);
        check("rt_index", 32'(bus.rt_index), 32'(e.idx));
        check("rt_insn",  32'(bus.rt_insn),  32'(e.insn));
        check("rt_prd",   32'(bus.rt_prd),   32'(e.prd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    bus.dp_insn = '0; bus.dp_pr1 = '0; bus.dp_pr2 = '0; bus.dp_prd = '0;
    bus.is_index = '0; bus.cm_index = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_dp_ready",  32'(bus.dp_ready),  32'd1);
    check("rst_rt_valid",  32'(bus.rt_valid),  32'd0);
    check("rst_iq_rd",     32'(bus.iq_rd),     32'd0);
    check("rst_iq_valid",  32'(bus.iq_valid),  32'd0);
    check("rst_iq_issue",  32'(bus.iq_issue),  32'd0);
    check("rst_iq_commit", 32'(bus.iq_commit), 32'd0);
    check("rst_iq0_insn",  32'(bus.iq0_insn),  32'd0);
    check("rst_iq3_prd",   32'(bus.iq3_prd),   32'd0);

    // Fill the queue, then a 5th dispatch is dropped
    for (int i = 0; i < 4; i++)
      dispatch(16'h1000 + 16'(i), 4'(4 + i));
    check("full_iq_valid", 32'(bus.iq_valid), 32'hF);
    check("full_dp_ready", 32'(bus.dp_ready), 32'd0);
    check("full_iq_rd",    32'(bus.iq_rd),    32'd0);
    check("iq1_pr1",       32'(bus.iq1_pr1),  32'd6);
    check("iq2_pr2",       32'(bus.iq2_pr2),  32'd8);
    set_dp(16'h2EEE, 4'd15);
    tick();
    bus.dp_valid = 1'b0;
    check("drop_iq0_insn",  32'(bus.iq0_insn), 32'h1000);
    check("drop_iq3_insn",  32'(bus.iq3_insn), 32'h1003);
    check("drop_iq_valid",  32'(bus.iq_valid), 32'hF);

    // Out-of-order issue/complete of entry 2; head still blocked
    issue(2'd2);
    check("is2_iq_issue", 32'(bus.iq_issue), 32'b0100);
    complete(2'd2);
    check("cm2_iq_commit", 32'(bus.iq_commit), 32'b0100);
    check("cm2_rt_valid",  32'(bus.rt_valid),  32'd0);
    complete(2'd3);
    check("cm_unissued_iq_commit", 32'(bus.iq_commit), 32'b0100);
    issue(2'd2);
    check("is_reissue_iq_issue", 32'(bus.iq_issue), 32'b0100);

    // In-order retirement of 0, 1, 2 on consecutive cycles
    issue(2'd0);
    issue(2'd1);
    complete(2'd0);
    check("cm0_rt_valid", 32'(bus.rt_valid), 32'd1);
    check("cm0_rt_index", 32'(bus.rt_index), 32'd0);
    complete(2'd1);
    check("rt1_iq_rd",    32'(bus.iq_rd),    32'd1);
    check("rt1_rt_valid", 32'(bus.rt_valid), 32'd1);
    tick();
    check("rt2_iq_rd",    32'(bus.iq_rd),    32'd2);
    check("rt2_rt_valid", 32'(bus.rt_valid), 32'd1);
    tick();
    check("after_rt_iq_rd",    32'(bus.iq_rd),    32'd3);
    check("after_rt_rt_valid", 32'(bus.rt_valid), 32'd0);
    check("after_rt_iq_valid", 32'(bus.iq_valid), 32'b1000);
    check("after_rt_dp_ready", 32'(bus.dp_ready), 32'd1);
    check("after_rt_retired",  32'(n_retired),    32'd3);
    issue(2'd0);
    check("is_invalid_iq_issue", 32'(bus.iq_issue), 32'b0000);

    // Drain entry 3 so the head wraps to 0
    issue(2'd3);
    complete(2'd3);
    check("cm3_rt_valid", 32'(bus.rt_valid), 32'd1);
    tick();
    check("empty_iq_rd",    32'(bus.iq_rd),    32'd0);
    check("empty_iq_valid", 32'(bus.iq_valid), 32'd0);
    check("empty_retired",  32'(n_retired),    32'd4);

    // Full queue with complete head and dispatch held: no same-cycle bypass
    for (int i = 0; i < 4; i++)
      dispatch(16'h2000 + 16'(i), 4'(8 + i));
    check("full2_iq_valid", 32'(bus.iq_valid), 32'hF);
    issue(2'd0);
    complete(2'd0);
    set_dp(16'h3000, 4'd12);
    check("hold_rt_valid", 32'(bus.rt_valid), 32'd1);
    check("hold_dp_ready", 32'(bus.dp_ready), 32'd0);
    tick();
    check("hold2_dp_ready", 32'(bus.dp_ready), 32'd1);
    check("hold2_iq_rd",    32'(bus.iq_rd),    32'd1);
    check("hold2_iq_valid", 32'(bus.iq_valid), 32'b1110);
    check("hold2_iq0_insn", 32'(bus.iq0_insn), 32'h2000);
    tick();
    bus.dp_valid = 1'b0;
    push_exp(16'h3000, 4'd12);
    check("wrap_iq_valid", 32'(bus.iq_valid), 32'hF);
    check("wrap_iq0_insn", 32'(bus.iq0_insn), 32'h3000);
    check("wrap_iq0_prd",  32'(bus.iq0_prd),  32'd12);
    check("wrap_dp_ready", 32'(bus.dp_ready), 32'd0);
    check("wrap_iq_issue", 32'(bus.iq_issue), 32'd0);

    // Flush together with dispatch, issue and retire
    issue(2'd1);
    issue(2'd2);
    complete(2'd1);
    check("pre_fl_rt_index", 32'(bus.rt_index), 32'd1);
    complete(2'd2);
    check("pre_fl_rt_valid", 32'(bus.rt_valid), 32'd1);
    check("pre_fl_dp_ready", 32'(bus.dp_ready), 32'd1);
    bus.flush = 1'b1;
    set_dp(16'h4000, 4'd14);
    bus.is_valid = 1'b1;
    bus.is_index = 2'd3;
    tick();
    idle();
    exp_q.delete();
    m_tail = 2'd0;
    check("fl_iq_valid",  32'(bus.iq_valid),  32'd0);
    check("fl_iq_issue",  32'(bus.iq_issue),  32'd0);
    check("fl_iq_commit", 32'(bus.iq_commit), 32'd0);
    check("fl_iq_rd",     32'(bus.iq_rd),     32'd0);
    check("fl_dp_ready",  32'(bus.dp_ready),  32'd1);
    check("fl_rt_valid",  32'(bus.rt_valid),  32'd0);
    check("fl_iq0_insn",  32'(bus.iq0_insn),  32'h3000);
    check("fl_iq1_insn",  32'(bus.iq1_insn),  32'h2001);
    check("fl_retired",   32'(n_retired),     32'd7);

    // Reset with three live entries
    dispatch(16'h5000, 4'd1);
    dispatch(16'h5001, 4'd2);
    dispatch(16'h5002, 4'd3);
    issue(2'd1);
    check("pre_rst_iq_valid", 32'(bus.iq_valid), 32'b0111);
    check("pre_rst_iq_issue", 32'(bus.iq_issue), 32'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_tail = 2'd0;
    check("mid_rst_iq_valid", 32'(bus.iq_valid), 32'd0);
    check("mid_rst_iq_issue", 32'(bus.iq_issue), 32'd0);
    check("mid_rst_iq_rd",    32'(bus.iq_rd),    32'd0);
    check("mid_rst_dp_ready", 32'(bus.dp_ready), 32'd1);
    check("mid_rst_rt_valid", 32'(bus.rt_valid), 32'd0);
    check("mid_rst_iq0_insn", 32'(bus.iq0_insn), 32'd0);
    dispatch(16'h6000, 4'd13);
    check("post_rst_iq_valid", 32'(bus.iq_valid), 32'b0001);
    check("post_rst_iq0_insn", 32'(bus.iq0_insn), 32'h6000);
    issue(2'd0);
    complete(2'd0);
    for (int i = 0; i < 10 && n_retired < 8; i++)
      tick();
    check("final_retired",  32'(n_retired),    32'd8);
    check("final_iq_valid", 32'(bus.iq_valid), 32'd0);
    check("final_iq_rd",    32'(bus.iq_rd),    32'd1);
    check("final_exp_q",    32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
